// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op encodings, FSM state encoding and the STEP_BITS legality rule.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldivOp_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldivState_e;

  // A step size is usable when it is 1, 2 or 4 bits and splits an even XLEN evenly.
  function automatic bit stepBitsLegal(input int xlen, input int stepBits);
    return ((stepBits == 1) || (stepBits == 2) || (stepBits == 4)) &&
           (xlen > 0) && ((xlen % 2) == 0) && ((xlen % stepBits) == 0);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2^STEP_BITS iteration of the multiply/divide datapath.
// Multiply: shift-add of the multiplicand into a 2*XLEN product.
// Divide:   restoring compare-subtract on {remainder, dividend/quotient}.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1
) (
  input  logic              i_isDiv,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [2*XLEN-1:0] i_mcand,
  input  logic [XLEN-1:0]   i_aux,
  output logic [2*XLEN-1:0] o_acc,
  output logic [2*XLEN-1:0] o_mcand,
  output logic [XLEN-1:0]   o_aux
);

  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_mcand;
  logic [XLEN-1:0]   w_mplier;
  logic [XLEN:0]     w_remWide;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_quo;

  // Unrolled STEP_BITS iterations; i_aux is the multiplier for MUL and the divisor for DIV.
  always_comb begin
    w_prod    = i_acc;
    w_mcand   = i_mcand;
    w_mplier  = i_aux;
    w_rem     = i_acc[2*XLEN-1:XLEN];
    w_quo     = i_acc[XLEN-1:0];
    w_remWide = '0;
    for (int k = 0; k < STEP_BITS; k++) begin
      if (w_mplier[0]) begin
        w_prod = w_prod + w_mcand;
      end
      w_mcand  = w_mcand << 1;
      w_mplier = w_mplier >> 1;

      w_remWide = {w_rem, w_quo[XLEN-1]};
      w_quo     = w_quo << 1;
      if (w_remWide >= {1'b0, i_aux}) begin
        w_remWide = w_remWide - {1'b0, i_aux};
        w_quo[0]  = 1'b1;
      end
      w_rem = w_remWide[XLEN-1:0];
    end

    if (i_isDiv) begin
      o_acc   = {w_rem, w_quo};
      o_mcand = i_mcand;
      o_aux   = i_aux;
    end else begin
      o_acc   = w_prod;
      o_mcand = w_mcand;
      o_aux   = w_mplier;
    end
  end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Holds the pipeline with stall while iterating, then pulses done with result and rd_out.
// Build option: define MULDIV_DIV_EN to include the divide datapath; without it,
// DIV/DIVU/REM/REMU finish immediately with result 0 and illegal set.
module riscv_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            illegal
);

  // An unsupported STEP_BITS falls back to one bit per cycle so results stay correct.
  localparam int EFF_STEP = stepBitsLegal(XLEN, STEP_BITS) ? STEP_BITS : 1;
  localparam int NSTEPS   = XLEN / EFF_STEP;
  localparam int CW       = $clog2(NSTEPS + 1);

  muldivState_e      r_state;
  muldivState_e      w_nextState;
  logic [2:0]        r_op;
  logic [4:0]        r_rdOut;
  logic              r_aNeg;
  logic              r_bNeg;
  logic              r_illegal;
  logic [CW-1:0]     r_count;
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0]   r_aux;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_lastStep;
  logic              w_aSigned;
  logic              w_bSigned;
  logic              w_aNeg;
  logic              w_bNeg;
  logic [XLEN-1:0]   w_aMag;
  logic [XLEN-1:0]   w_bMag;
  logic              w_fast;
  logic              w_fastIllegal;
  logic [XLEN-1:0]   w_fastResult;
  logic              w_stepIsDiv;
  logic [2*XLEN-1:0] w_stepAcc;
  logic [2*XLEN-1:0] w_stepMcand;
  logic [XLEN-1:0]   w_stepAux;
  logic [2*XLEN-1:0] w_prodSigned;
  logic [XLEN-1:0]   w_mulResult;
  logic [XLEN-1:0]   w_finalResult;

  assign w_accept   = start & (r_state == IDLE) & ~flush;
  assign w_lastStep = (r_count == CW'(NSTEPS - 1));

  // Signedness per op: DIV/REM signed, DIVU/REMU unsigned, MULHSU signed a only, MULHU unsigned.
  assign w_aSigned = op[2] ? ~op[0] : (op != OP_MULHU);
  assign w_bSigned = op[2] ? ~op[0] : ((op == OP_MUL) || (op == OP_MULH));
  assign w_aNeg    = w_aSigned & a[XLEN-1];
  assign w_bNeg    = w_bSigned & b[XLEN-1];
  assign w_aMag    = w_aNeg ? -a : a;
  assign w_bMag    = w_bNeg ? -b : b;

`ifdef MULDIV_DIV_EN
  logic            w_divZero;
  logic            w_overflow;
  logic [XLEN-1:0] w_quoSigned;
  logic [XLEN-1:0] w_remSigned;

  assign w_divZero   = (b == '0);
  assign w_overflow  = ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
  assign w_fast      = op[2] & (w_divZero | w_overflow);
  assign w_fastIllegal = 1'b0;
  assign w_stepIsDiv = r_op[2];

  // Divide by zero and signed overflow have architecturally fixed answers.
  always_comb begin
    w_fastResult = '0;
    if (w_divZero) begin
      w_fastResult = op[1] ? a : '1;
    end else begin
      w_fastResult = op[1] ? '0 : a;
    end
  end

  assign w_quoSigned   = (r_aNeg ^ r_bNeg) ? -w_stepAcc[XLEN-1:0] : w_stepAcc[XLEN-1:0];
  assign w_remSigned   = r_aNeg ? -w_stepAcc[2*XLEN-1:XLEN] : w_stepAcc[2*XLEN-1:XLEN];
  assign w_finalResult = r_op[2] ? (r_op[1] ? w_remSigned : w_quoSigned) : w_mulResult;
`else
  assign w_fast        = op[2];
  assign w_fastIllegal = 1'b1;
  assign w_fastResult  = '0;
  assign w_stepIsDiv   = 1'b0;
  assign w_finalResult = w_mulResult;
`endif

  // Product sign is applied once, after the last magnitude step.
  assign w_prodSigned = (r_aNeg ^ r_bNeg) ? -w_stepAcc : w_stepAcc;
  assign w_mulResult  = (r_op == OP_MUL) ? w_prodSigned[XLEN-1:0] : w_prodSigned[2*XLEN-1:XLEN];

  muldiv_step #(
    .XLEN      (XLEN),
    .STEP_BITS (EFF_STEP)
  ) u_step (
    .i_isDiv (w_stepIsDiv),
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_aux   (r_aux),
    .o_acc   (w_stepAcc),
    .o_mcand (w_stepMcand),
    .o_aux   (w_stepAux)
  );

  // State register; reset drops any operation in flight without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and pipeline handshake; stall drops in DONE so EX advances with done.
  always_comb begin
    w_nextState = r_state;
    stall       = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          stall       = 1'b1;
          w_nextState = w_fast ? DONE : CALC;
        end
      end
      CALC: begin
        stall = 1'b1;
        if (flush) begin
          w_nextState = IDLE;
        end else if (w_lastStep) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        done        = ~flush;
        illegal     = r_illegal & ~flush;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Operand capture on acceptance, one datapath step per CALC cycle, result capture on exit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op      <= '0;
      r_rdOut   <= '0;
      r_aNeg    <= 1'b0;
      r_bNeg    <= 1'b0;
      r_illegal <= 1'b0;
      r_count   <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_aux     <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op      <= op;
            r_rdOut   <= rd_in;
            r_aNeg    <= w_aNeg;
            r_bNeg    <= w_bNeg;
            r_count   <= '0;
            r_aux     <= w_bMag;
            r_illegal <= w_fast & w_fastIllegal;
            if (op[2]) begin
              r_acc   <= {{XLEN{1'b0}}, w_aMag};
              r_mcand <= '0;
            end else begin
              r_acc   <= '0;
              r_mcand <= {{XLEN{1'b0}}, w_aMag};
            end
            if (w_fast) begin
              r_result <= w_fastResult;
            end
          end
        end
        CALC: begin
          r_acc   <= w_stepAcc;
          r_mcand <= w_stepMcand;
          r_aux   <= w_stepAux;
          if (flush || w_lastStep) begin
            r_count <= '0;
          end else begin
            r_count <= r_count + CW'(1);
          end
          if (!flush && w_lastStep) begin
            r_result <= w_finalResult;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result = r_result;
  assign rd_out = r_rdOut;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Self-checking bench for riscv_muldiv_unit (XLEN=32, STEP_BITS=1).
// Expected values come from plain 64-bit arithmetic on the RV32M rules.
module tb_riscv_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd_in;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        illegal;

  int nChecks = 0;
  int nFails  = 0;

  localparam int FULL_LAT = 33;

  localparam logic [2:0]  V_OP  [13] = '{3'd0, 3'd3, 3'd2, 3'd0, 3'd4, 3'd6, 3'd5,
                                          3'd4, 3'd5, 3'd7, 3'd4, 3'd6, 3'd1};
  localparam logic [31:0] V_A   [13] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3,
                                          32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'h80000000,
                                          32'd5, 32'd5, 32'd8, 32'h80000000, 32'h80000000};
  localparam logic [31:0] V_B   [13] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2, 32'd4,
                                          32'd2, 32'd2, 32'd7, 32'hFFFFFFFF,
                                          32'd0, 32'd0, 32'd2, 32'hFFFFFFFF, 32'h80000000};
  localparam logic [31:0] V_RES [13] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd12,
                                          32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'h80000000,
                                          32'hFFFFFFFF, 32'd5, 32'd4, 32'd0, 32'h40000000};
  localparam int          V_LAT [13] = '{33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 33, 1, 33};

  riscv_muldiv_unit #(
    .XLEN      (32),
    .STEP_BITS (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .rd_in   (rd_in),
    .stall   (stall),
    .done    (done),
    .result  (result),
    .rd_out  (rd_out),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RV32M semantics from 64-bit arithmetic; SV / and % truncate like RISC-V.
  function automatic void refCalc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] res, output int lat, output logic ill);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    bit dz, ovf;
    sx  = $signed(x);
    sy  = $signed(y);
    ux  = longint'({32'd0, x});
    uy  = longint'({32'd0, y});
    dz  = (y == 32'd0);
    ovf = (x == 32'h80000000) && (y == 32'hFFFFFFFF);
    lat = FULL_LAT;
    ill = 1'b0;
    p   = '0;
    case (o)
      3'd0: p = sx * sy;
      3'd1: p = sx * sy;
      3'd2: p = sx * uy;
      3'd3: p = ux * uy;
      3'd4: if (dz) p = '1; else if (ovf) p = {32'd0, x}; else p = sx / sy;
      3'd5: if (dz) p = '1; else p = ux / uy;
      3'd6: if (dz) p = {32'd0, x}; else if (ovf) p = '0; else p = sx % sy;
      default: if (dz) p = {32'd0, x}; else p = ux % uy;
    endcase
    res = ((o == 3'd1) || (o == 3'd2) || (o == 3'd3)) ? p[63:32] : p[31:0];
    if (o[2] && (dz || (ovf && !o[0]))) lat = 1;
`ifndef MULDIV_DIV_EN
    if (o[2]) begin
      res = '0;
      lat = 1;
      ill = 1'b1;
    end
`endif
  endfunction

  // Issue one op, scramble inputs after acceptance, and time the done pulse.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                               input logic [4:0] r, input bit noisy,
                               output logic [31:0] res, output int lat, output logic ill,
                               output logic [4:0] rdo, output int stallCnt,
                               output logic stallStart, output logic stallDone, output bit ok);
    @(negedge clk);
    op = o; a = x; b = y; rd_in = r; start = 1'b1;
    #1 stallStart = stall;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom; rd_in = 5'($urandom);
    lat = 1; stallCnt = 0; ok = 0; res = '0; ill = 1'b0; rdo = '0; stallDone = 1'b0;
    while (!ok && lat <= 40) begin
      if (done) begin
        ok = 1; res = result; ill = illegal; rdo = rd_out; stallDone = stall;
      end else begin
        if (stall) stallCnt++;
        if (noisy) begin
          start = 1'($urandom); op = 3'($urandom); a = $urandom; b = $urandom;
        end
        @(posedge clk); #1;
        lat++;
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  // Compares one completed op against expectations.
  task automatic checkOutput(input string tag, input bit ok, input logic [31:0] res, input logic [31:0] expRes,
                             input int lat, input int expLat, input logic ill, input logic expIll,
                             input logic [4:0] rdo, input logic [4:0] expRd, input int stallCnt,
                             input logic stallStart, input logic stallDone);
    nChecks++;
    if (!ok) begin
      nFails++;
      $display("[TB] FAIL %s timeout: no done within 40 cycles, expected latency %0d", tag, expLat);
    end else begin
      nChecks++;
      if (res !== expRes) begin nFails++; $display("[TB] FAIL %s result: got %h expected %h", tag, res, expRes); end
      nChecks++;
      if (lat !== expLat) begin nFails++; $display("[TB] FAIL %s latency: got %0d expected %0d", tag, lat, expLat); end
      nChecks++;
      if (ill !== expIll) begin nFails++; $display("[TB] FAIL %s illegal: got %b expected %b", tag, ill, expIll); end
      nChecks++;
      if (rdo !== expRd) begin nFails++; $display("[TB] FAIL %s rd_out: got %0d expected %0d", tag, rdo, expRd); end
      nChecks++;
      if (stallCnt !== expLat - 1) begin nFails++; $display("[TB] FAIL %s stall cycles: got %0d expected %0d", tag, stallCnt, expLat - 1); end
      nChecks++;
      if (stallDone !== 1'b0) begin nFails++; $display("[TB] FAIL %s stall in done cycle: got %b expected 0", tag, stallDone); end
    end
    nChecks++;
    if (stallStart !== 1'b1) begin nFails++; $display("[TB] FAIL %s stall on start cycle: got %b expected 1", tag, stallStart); end
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; rd_in = '0;
    #1;
    nChecks++;
    if ({stall, done, illegal} !== 3'b000) begin nFails++; $display("[TB] FAIL reset flags: got %b expected 000", {stall, done, illegal}); end
    nChecks++;
    if (result !== 32'd0) begin nFails++; $display("[TB] FAIL reset result: got %h expected 0", result); end
    nChecks++;
    if (rd_out !== 5'd0) begin nFails++; $display("[TB] FAIL reset rd_out: got %0d expected 0", rd_out); end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] res, expRes; logic [4:0] rdo; logic ill, expIll, sS, sD, o; int lat, expLat, sc; bit ok;
    logic [2:0] vop;
    for (int i = 0; i < 13; i++) begin
      vop = V_OP[i]; expRes = V_RES[i]; expLat = V_LAT[i]; expIll = 1'b0; o = vop[2];
`ifndef MULDIV_DIV_EN
      if (o) begin expRes = '0; expLat = 1; expIll = 1'b1; end
`endif
      applyStimulus(vop, V_A[i], V_B[i], 5'(i + 1), 1'b0, res, lat, ill, rdo, sc, sS, sD, ok);
      checkOutput($sformatf("directed[%0d] op%0d", i, vop), ok, res, expRes, lat, expLat, ill, expIll,
                  rdo, 5'(i + 1), sc, sS, sD);
    end
  endtask

  task automatic test_random(input int n, input bit allowNoise);
    logic [31:0] res, expRes, x, y; logic [4:0] rdo, r; logic ill, expIll, sS, sD; logic [2:0] o;
    int lat, expLat, sc, kind; bit ok;
    for (int i = 0; i < n; i++) begin
      o = 3'($urandom_range(0, 7)); r = 5'($urandom); x = $urandom; y = $urandom;
      kind = $urandom_range(0, 7);
      if (kind == 0) y = 32'd0;
      else if (kind == 1) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
      else if (kind == 2) begin x = $urandom_range(0, 255); y = $urandom_range(1, 15); end
      refCalc(o, x, y, expRes, expLat, expIll);
      applyStimulus(o, x, y, r, allowNoise && ($urandom_range(0, 1) == 1), res, lat, ill, rdo, sc, sS, sD, ok);
      checkOutput($sformatf("random[%0d] op%0d a=%h b=%h", i, o, x, y), ok, res, expRes, lat, expLat,
                  ill, expIll, rdo, r, sc, sS, sD);
    end
  endtask

  task automatic test_flush();
    int seen;
    @(negedge clk);
    op = 3'd0; a = 32'd1234; b = 32'd5678; rd_in = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    nChecks++;
    if ({stall, done} !== 2'b00) begin nFails++; $display("[TB] FAIL flush mid-calc: stall/done got %b expected 00", {stall, done}); end
    seen = 0;
    repeat (40) begin
      if (done || stall) seen++;
      @(posedge clk); #1;
    end
    nChecks++;
    if (seen !== 0) begin nFails++; $display("[TB] FAIL flush aftermath: got %0d active cycles expected 0", seen); end
    @(negedge clk);
    op = 3'd4; a = 32'd100; b = 32'd3; start = 1'b1; flush = 1'b1;
    #1;
    nChecks++;
    if (stall !== 1'b0) begin nFails++; $display("[TB] FAIL flush with start stall: got %b expected 0", stall); end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    seen = 0;
    repeat (40) begin
      if (done || stall) seen++;
      @(posedge clk); #1;
    end
    nChecks++;
    if (seen !== 0) begin nFails++; $display("[TB] FAIL flush beats start: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res, expRes; logic [4:0] rdo; logic ill, expIll, sS, sD; int lat, expLat, sc; bit ok;
    logic [2:0] ops [4];
    logic [31:0] xs [4];
    logic [31:0] ys [4];
    ops = '{3'd0, 3'd5, 3'd1, 3'd6};
    xs  = '{32'h00012345, 32'd1000, 32'hFFFF0000, 32'hFFFFFF00};
    ys  = '{32'h00000321, 32'd33, 32'h00020000, 32'd7};
    for (int i = 0; i < 4; i++) begin
      refCalc(ops[i], xs[i], ys[i], expRes, expLat, expIll);
      applyStimulus(ops[i], xs[i], ys[i], 5'(20 + i), 1'b1, res, lat, ill, rdo, sc, sS, sD, ok);
      checkOutput($sformatf("b2b[%0d]", i), ok, res, expRes, lat, expLat, ill, expIll, rdo, 5'(20 + i), sc, sS, sD);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] res, expRes; logic [4:0] rdo; logic ill, expIll, sS, sD; int lat, expLat, sc, seen; bit ok;
    @(negedge clk);
    op = 3'd0; a = 32'd77; b = 32'd99; rd_in = 5'd17; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    nChecks++;
    if ({stall, done, illegal} !== 3'b000) begin nFails++; $display("[TB] FAIL async reset flags: got %b expected 000", {stall, done, illegal}); end
    nChecks++;
    if (result !== 32'd0) begin nFails++; $display("[TB] FAIL async reset result: got %h expected 0", result); end
    nChecks++;
    if (rd_out !== 5'd0) begin nFails++; $display("[TB] FAIL async reset rd_out: got %0d expected 0", rd_out); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    nChecks++;
    if (seen !== 0) begin nFails++; $display("[TB] FAIL async reset done pulses: got %0d expected 0", seen); end
    refCalc(3'd3, 32'hDEADBEEF, 32'hCAFEF00D, expRes, expLat, expIll);
    applyStimulus(3'd3, 32'hDEADBEEF, 32'hCAFEF00D, 5'd9, 1'b0, res, lat, ill, rdo, sc, sS, sD, ok);
    checkOutput("post-reset mulhu", ok, res, expRes, lat, expLat, ill, expIll, rdo, 5'd9, sc, sS, sD);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(40, 1'b1);
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
